// File: rtl/rgb565_px_assembler.sv
// rgb565_px_assembler
// Assembles RGB565 pixels from a byte stream. The high byte arrives first.
// Tracks the column and row of each pixel within the frame, and flags
// end-of-line, end-of-frame and broken (restarted) frames.
module rgb565_px_assembler #(
   parameter int MAX_PIXEL_BITS = 16,
   parameter int IMG_WIDTH      = 160,
   parameter int IMG_HEIGHT     = 120,
   parameter int COL_BITS       = $clog2(IMG_WIDTH),
   parameter int ROW_BITS       = $clog2(IMG_HEIGHT)
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      byte_valid_i,
   input  logic [7:0]                byte_i,
   input  logic                      sof_i,
   output logic [MAX_PIXEL_BITS-1:0] out_px_rgb_o,
   output logic                      px_rdy_o,
   output logic [COL_BITS-1:0]       col_o,
   output logic [ROW_BITS-1:0]       row_o,
   output logic                      eol_o,
   output logic                      eof_o,
   output logic                      frame_err_o
);

   localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_WIDTH - 1);
   localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HI   = 2'd1,
      ST_LO   = 2'd2
   } state_t;

   state_t                    state_q,   state_d;
   logic [7:0]                hi_q,      hi_d;
   logic [COL_BITS-1:0]       col_cnt_q, col_cnt_d;   // position of the next pixel
   logic [ROW_BITS-1:0]       row_cnt_q, row_cnt_d;
   logic [MAX_PIXEL_BITS-1:0] out_px_q,  out_px_d;
   logic [COL_BITS-1:0]       col_q,     col_d;       // position of the presented pixel
   logic [ROW_BITS-1:0]       row_q,     row_d;
   logic                      px_rdy_q,  px_rdy_d;
   logic                      eol_q,     eol_d;
   logic                      eof_q,     eof_d;
   logic                      err_q,     err_d;
   logic                      start_frame;

   // Next-state logic. A qualified sof always restarts the frame, whatever
   // the state. Outside IDLE that restart also abandons the partial frame.
   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      col_cnt_d   = col_cnt_q;
      row_cnt_d   = row_cnt_q;
      out_px_d    = out_px_q;
      col_d       = col_q;
      row_d       = row_q;
      px_rdy_d    = 1'b0;
      eol_d       = 1'b0;
      eof_d       = 1'b0;
      err_d       = 1'b0;
      start_frame = byte_valid_i && sof_i;

      if (start_frame) begin
         // A pending half-pixel in LO is discarded simply by overwriting hi.
         hi_d      = byte_i;
         col_cnt_d = '0;
         row_cnt_d = '0;
         state_d   = ST_LO;
         err_d     = (state_q != ST_IDLE);
      end else if (byte_valid_i) begin
         case (state_q)
            ST_IDLE: begin
               // Bytes outside a frame are dropped.
            end
            ST_HI: begin
               hi_d    = byte_i;
               state_d = ST_LO;
            end
            ST_LO: begin
               out_px_d = MAX_PIXEL_BITS'({hi_q, byte_i});
               col_d    = col_cnt_q;
               row_d    = row_cnt_q;
               px_rdy_d = 1'b1;
               state_d  = ST_HI;
               if (col_cnt_q == LAST_COL) begin
                  eol_d     = 1'b1;
                  col_cnt_d = '0;
                  if (row_cnt_q == LAST_ROW) begin
                     eof_d     = 1'b1;
                     row_cnt_d = '0;
                     state_d   = ST_IDLE;
                  end else begin
                     row_cnt_d = row_cnt_q + ROW_BITS'(1);
                  end
               end else begin
                  col_cnt_d = col_cnt_q + COL_BITS'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State, data and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         hi_q      <= '0;
         col_cnt_q <= '0;
         row_cnt_q <= '0;
         out_px_q  <= '0;
         col_q     <= '0;
         row_q     <= '0;
         px_rdy_q  <= 1'b0;
         eol_q     <= 1'b0;
         eof_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         col_cnt_q <= col_cnt_d;
         row_cnt_q <= row_cnt_d;
         out_px_q  <= out_px_d;
         col_q     <= col_d;
         row_q     <= row_d;
         px_rdy_q  <= px_rdy_d;
         eol_q     <= eol_d;
         eof_q     <= eof_d;
         err_q     <= err_d;
      end
   end

   assign out_px_rgb_o = out_px_q;
   assign px_rdy_o     = px_rdy_q;
   assign col_o        = col_q;
   assign row_o        = row_q;
   assign eol_o        = eol_q;
   assign eof_o        = eof_q;
   assign frame_err_o  = err_q;

endmodule

// File: doc/rgb565_px_assembler.md
Name: rgb565_px_assembler

Overview:
- Producer end of the pixel interface that feeds the grayscale core.
- Takes an 8-bit byte stream from the camera/host front end and assembles RGB565 pixels, high byte first.
- Presents each pixel as `out_px_rgb_o` with a one-cycle `px_rdy_o` strobe.
- Tracks column and row position in the frame, flags end-of-line and end-of-frame, and detects broken frames.

Parameters:
- MAX_PIXEL_BITS, 16, assembled pixel width (RGB565: R[15:11], G[10:5], B[4:0]).
- IMG_WIDTH, 160, pixels per line.
- IMG_HEIGHT, 120, lines per frame.
- COL_BITS, $clog2(IMG_WIDTH), column counter width.
- ROW_BITS, $clog2(IMG_HEIGHT), row counter width.

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- reset_i  input  1  synchronous reset, active-high.
- byte_valid_i  input  1  byte_i carries a valid byte this cycle.
- byte_i  input  8  stream byte.
- sof_i  input  1  start-of-frame marker, qualified by byte_valid_i.
- out_px_rgb_o  output  MAX_PIXEL_BITS  assembled pixel, {hi_byte, lo_byte}.
- px_rdy_o  output  1  one-cycle strobe, out_px_rgb_o valid.
- col_o  output  COL_BITS  column of the pixel presented with px_rdy_o.
- row_o  output  ROW_BITS  row of the pixel presented with px_rdy_o.
- eol_o  output  1  asserted with px_rdy_o on the last pixel of a line.
- eof_o  output  1  asserted with px_rdy_o on the last pixel of a frame.
- frame_err_o  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset:
  - Sampled only on the rising edge of clk_i; it overrides every other input that cycle.
  - All outputs go to 0 and the FSM goes to IDLE.
  - The internal hi-byte register and the col/row counters clear.
- FSM states: IDLE, HI, LO.
  - IDLE: waits for sof_i && byte_valid_i. On that cycle the byte is latched as the high byte, counters clear to 0, and the FSM goes to LO. Valid bytes without sof_i are dropped silently.
  - HI: waits for byte_valid_i. On a valid byte it latches the high byte and goes to LO.
  - LO: waits for byte_valid_i. On a valid byte it registers {hi, byte_i} to out_px_rgb_o and asserts px_rdy_o the next cycle, with col_o/row_o holding the current position. It then goes to HI, or to IDLE if this was the last pixel of the frame.
- Latency: px_rdy_o, out_px_rgb_o, col_o, row_o, eol_o and eof_o are all registered one cycle after the low byte is accepted.
- Output hold:
  - out_px_rgb_o, col_o and row_o hold their values between strobes.
  - px_rdy_o, eol_o, eof_o and frame_err_o are single-cycle pulses.
- Counters:
  - col increments on each emitted pixel.
  - At IMG_WIDTH-1: eol_o = 1, col wraps to 0 and row increments.
  - At col = IMG_WIDTH-1 and row = IMG_HEIGHT-1: eof_o = 1 and eol_o = 1 together. Row wraps to 0 and the FSM returns to IDLE.
- byte_valid_i low: gaps of any length are allowed in HI and LO; state and latched data are held.
- sof_i with byte_valid_i outside IDLE:
  - The partial frame is abandoned and frame_err_o pulses the next cycle.
  - The byte is taken as the high byte of pixel (0,0) of a new frame, counters clear, and the FSM goes to LO.
  - This also applies when the violation arrives in LO, i.e. a half-pixel is pending; that pending high byte is discarded and no px_rdy_o is emitted for it.
- sof_i without byte_valid_i: ignored.
- sof_i in IDLE: normal start, no error.
- Throughput: one pixel per two valid bytes, so the maximum rate is one px_rdy_o every 2 cycles.

Test Plan:
- **Reset:** hold reset_i high for 3 cycles during a mid-pixel stream -> all outputs 0; subsequent bytes without sof_i are ignored (px_rdy_o stays 0).
- **Single pixel:** sof_i+byte 0xF8, then byte 0x1F -> one cycle later px_rdy_o=1, out_px_rgb_o=0xF81F, col_o=0, row_o=0, eol_o=0, frame_err_o=0.
- **Gapped bytes:** 0xAB, 3 idle cycles, 0xCD -> single px_rdy_o with 0xABCD, no extra strobes.
- **Full frame (IMG_WIDTH=4, IMG_HEIGHT=2), back-to-back:** 8 px_rdy_o strobes, every other cycle. eol_o on col 3 of rows 0 and 1; eof_o only on (3,1). FSM back in IDLE, so extra bytes produce no strobe.
- **Mid-pixel restart:** sof_i arrives in LO after hi byte 0x12, carrying byte 0x34, followed by 0x56 -> frame_err_o pulse, no pixel 0x12xx, then px_rdy_o with 0x3456 at col 0, row 0.
- **Mid-frame restart:** sof_i after 5 pixels of a 4x2 frame -> frame_err_o pulse; the next pixel reports col_o=0, row_o=0; eof_o appears only after 8 further pixels.
